// File: rtl/led_seq_pkg.sv
// led_seq_pkg: phase encoding and default pattern width for the LED fill sequencer.
// Built with or without LED_HOLD_EN; without it the HOLD encoding does not exist.
package led_seq_pkg;
    localparam int LED_WIDTH = 8;
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_FILL  = 2'd1,
`ifdef LED_HOLD_EN
        PH_HOLD  = 2'd2,
`endif
        PH_EMPTY = 2'd3
    } phase_t;
endpackage

// File: rtl/led_fill_seq_if.sv
// led_fill_seq_if: step/run controls and the pattern handshake to the display driver.
interface led_fill_seq_if import led_seq_pkg::*; #(parameter int WIDTH = LED_WIDTH);
    logic             step_clk;
    logic             run;
    logic [WIDTH-1:0] led;
    logic             led_valid;
    logic             led_ready;
    logic [1:0]       phase;
    logic             overrun;
    modport master (input step_clk, run, led_ready, output led, led_valid, phase, overrun);
    modport slave  (output step_clk, run, led_ready, input led, led_valid, phase, overrun);
endinterface

// File: rtl/led_fill_seq_step_sync.sv
// step_sync: two-flop synchronizer and rising-edge detector for step_clk,
// with detection held off for three cycles after reset release.
module step_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic step_clk,
    output logic step
);
    logic [2:0] sh;
    logic [1:0] cnt;
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            sh  <= {sh[1:0], step_clk};
            cnt <= cnt + {1'b0, cnt != 2'd3};
        end
    end
    // a step_clk already high at release would otherwise look like a rise
    assign step = sh[1] && !sh[2] && cnt == 2'd3;
endmodule

// File: rtl/led_fill_seq.sv
// led_fill_seq: LED fill/empty pattern sequencer with valid/ready handoff.
// Optional HOLD phase at full pattern when LED_HOLD_EN is defined.
module led_fill_seq import led_seq_pkg::*; #(
    parameter int WIDTH      = LED_WIDTH,
    parameter int HOLD_STEPS = 4
) (
    input  logic           clk_in,
    input  logic           rst_n,
    led_fill_seq_if.master bus
);
    phase_t           state, state_nxt;
    logic [WIDTH-1:0] led, led_nxt, fill_pat, empty_pat;
    logic             led_valid, overrun, step, stalled, accept;
`ifdef LED_HOLD_EN
    localparam int HW = $clog2(HOLD_STEPS + 1);
    logic [HW-1:0] hold_cnt, hold_nxt;
`endif

    step_sync u_sync (.clk_in(clk_in), .rst_n(rst_n), .step_clk(bus.step_clk), .step(step));

    assign fill_pat  = {led[WIDTH-2:0], 1'b1};
    assign empty_pat = {led[WIDTH-2:0], 1'b0};
    assign stalled   = led_valid && !bus.led_ready;
    assign accept    = step && !stalled;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= PH_IDLE;
            led       <= '0;
            led_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef LED_HOLD_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            led       <= led_nxt;
            led_valid <= (led_nxt != led) || stalled;
            overrun   <= overrun || (step && stalled);
`ifdef LED_HOLD_EN
            hold_cnt  <= hold_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        led_nxt   = led;
`ifdef LED_HOLD_EN
        hold_nxt  = hold_cnt;
`endif
        if (!bus.run) begin
            state_nxt = PH_IDLE;
            led_nxt   = '0;
        end else if (accept) begin
            case (state)
                PH_IDLE: begin
                    state_nxt = PH_FILL;
                    led_nxt   = fill_pat;
                end
                PH_FILL: begin
                    led_nxt = fill_pat;
                    if (&fill_pat) begin
`ifdef LED_HOLD_EN
                        state_nxt = PH_HOLD;
                        hold_nxt  = '0;
`else
                        state_nxt = PH_EMPTY;
`endif
                    end
                end
`ifdef LED_HOLD_EN
                // the last hold step already performs the first EMPTY shift
                PH_HOLD: begin
                    if (hold_cnt == HW'(HOLD_STEPS - 1)) begin
                        state_nxt = PH_EMPTY;
                        led_nxt   = empty_pat;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
`endif
                PH_EMPTY: begin
                    led_nxt = empty_pat;
                    if (empty_pat == '0) state_nxt = PH_FILL;
                end
                default: state_nxt = PH_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.led       = led;
        bus.led_valid = led_valid;
        bus.phase     = state;
        bus.overrun   = overrun;
    end
endmodule

// File: tb/tb_led_fill_seq.sv
// tb_led_fill_seq: directed checks of the fill/hold/empty sequence, handshake,
// overrun, run drop and reset behaviour.
module tb_led_fill_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef LED_HOLD_EN
    localparam logic [1:0] PH_FULL = 2'd2;
`else
    localparam logic [1:0] PH_FULL = 2'd3;
`endif

    led_fill_seq_if bus ();
    led_fill_seq #(.WIDTH(8), .HOLD_STEPS(4)) dut (.clk_in(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

`ifndef LED_HOLD_EN
    always @(negedge clk) begin
        n_cmp++;
        if (bus.phase === 2'd2) begin
            n_bad++;
            $display("FAIL no_hold_phase got %0d want !=2", bus.phase);
        end
    end
`endif

    task automatic do_step();
        bus.step_clk = 1'b1;
        repeat (3) @(negedge clk);
        repeat (1) @(negedge clk);
        bus.step_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.step_clk = 1'b0;
        bus.run = 1'b0;
        bus.led_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.led, bus.led_valid, bus.phase, bus.overrun} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset got led=%h v=%b ph=%0d ov=%b want 00 0 0 0", bus.led, bus.led_valid, bus.phase, bus.overrun);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_latency();
        bus.run = 1'b1;
        bus.step_clk = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.led !== 8'h00) begin
                n_bad++;
                $display("FAIL latency_edge%0d led got %h want 00", i, bus.led);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.led, bus.phase, bus.led_valid} !== {8'h01, 2'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL latency_edge3 got led=%h ph=%0d v=%b want 01 1 1", bus.led, bus.phase, bus.led_valid);
        end
        @(negedge clk);
        bus.step_clk = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.led_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_clear got %b want 0", bus.led_valid);
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp_led [7] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        for (int i = 0; i < 7; i++) begin
            do_step();
            n_cmp++;
            if ({bus.led, bus.phase} !== {exp_led[i], (i == 6) ? PH_FULL : 2'd1}) begin
                n_bad++;
                $display("FAIL fill%0d got led=%h ph=%0d want %h %0d", i, bus.led, bus.phase, exp_led[i], (i == 6) ? PH_FULL : 2'd1);
            end
        end
    endtask

    task automatic test_hold_empty();
        logic [7:0] exp_led [7] = '{8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
`ifdef LED_HOLD_EN
        for (int i = 0; i < 3; i++) begin
            do_step();
            n_cmp++;
            if ({bus.led, bus.phase} !== {8'hFF, 2'd2}) begin
                n_bad++;
                $display("FAIL hold%0d got led=%h ph=%0d want FF 2", i, bus.led, bus.phase);
            end
        end
`endif
        do_step();
        n_cmp++;
        if ({bus.led, bus.phase} !== {8'hFE, 2'd3}) begin
            n_bad++;
            $display("FAIL empty_first got led=%h ph=%0d want FE 3", bus.led, bus.phase);
        end
        for (int i = 0; i < 7; i++) begin
            do_step();
            n_cmp++;
            if ({bus.led, bus.phase} !== {exp_led[i], (i == 6) ? 2'd1 : 2'd3}) begin
                n_bad++;
                $display("FAIL empty%0d got led=%h ph=%0d want %h %0d", i, bus.led, bus.phase, exp_led[i], (i == 6) ? 2'd1 : 2'd3);
            end
        end
        do_step();
        n_cmp++;
        if ({bus.led, bus.phase} !== {8'h01, 2'd1}) begin
            n_bad++;
            $display("FAIL refill got led=%h ph=%0d want 01 1", bus.led, bus.phase);
        end
    endtask

    task automatic test_overrun();
        do_step();
        n_cmp++;
        if (bus.led !== 8'h03 || bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_start got led=%h ov=%b want 03 0", bus.led, bus.overrun);
        end
        bus.led_ready = 1'b0;
        do_step();
        do_step();
        n_cmp++;
        if ({bus.led, bus.overrun, bus.led_valid} !== {8'h07, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL ovr_drop got led=%h ov=%b v=%b want 07 1 1", bus.led, bus.overrun, bus.led_valid);
        end
        bus.led_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.led, bus.overrun, bus.led_valid} !== {8'h07, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ovr_release got led=%h ov=%b v=%b want 07 1 0", bus.led, bus.overrun, bus.led_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.led_ready = 1'b0;
        do_step();
        bus.step_clk = 1'b1;
        repeat (2) @(negedge clk);
        bus.led_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.led, bus.led_valid} !== {8'h1F, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_accept got led=%h v=%b want 1F 1", bus.led, bus.led_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.led_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_clear got v=%b want 0", bus.led_valid);
        end
        bus.step_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_run_drop();
        bus.run = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.led, bus.phase, bus.led_valid} !== {8'h00, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL run_drop got led=%h ph=%0d v=%b want 00 0 1", bus.led, bus.phase, bus.led_valid);
        end
        do_step();
        n_cmp++;
        if ({bus.led, bus.phase, bus.led_valid} !== {8'h00, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_step got led=%h ph=%0d v=%b want 00 0 0", bus.led, bus.phase, bus.led_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.run = 1'b1;
        bus.led_ready = 1'b0;
        do_step();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.led, bus.led_valid, bus.phase, bus.overrun} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_mid got led=%h v=%b ph=%0d ov=%b want 00 0 0 0", bus.led, bus.led_valid, bus.phase, bus.overrun);
        end
    endtask

    task automatic test_release_high();
        bus.led_ready = 1'b1;
        bus.step_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({bus.led, bus.phase} !== {8'h00, 2'd0}) begin
            n_bad++;
            $display("FAIL release_high got led=%h ph=%0d want 00 0", bus.led, bus.phase);
        end
        bus.step_clk = 1'b0;
        repeat (3) @(negedge clk);
        do_step();
        n_cmp++;
        if ({bus.led, bus.phase} !== {8'h01, 2'd1}) begin
            n_bad++;
            $display("FAIL release_step got led=%h ph=%0d want 01 1", bus.led, bus.phase);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_hold_empty();
        test_overrun();
        test_back_to_back();
        test_run_drop();
        test_reset_mid();
        test_release_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/led_fill_seq.md
LED_FILL_SEQ -- requirements
Module: led_fill_seq

Interface
REQ-001 Parameter WIDTH, default 8: number of LEDs in the pattern.
REQ-002 Parameter HOLD_STEPS, default 4: number of steps the full pattern is held when the hold feature is compiled in.
REQ-003 Port clk_in, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port step_clk, input, 1 bit: square wave from the clock divider; each rising edge is one step.
REQ-006 Port run, input, 1 bit: 1 enables the sequence; 0 returns to IDLE.
REQ-007 Port led, output, WIDTH bits: current LED pattern (bit 0 lights first).
REQ-008 Port led_valid, output, 1 bit: a new pattern is awaiting transfer to the display driver.
REQ-009 Port led_ready, input, 1 bit: the display driver accepts the pattern.
REQ-010 Port phase, output, 2 bits: state encoding IDLE=0, FILL=1, HOLD=2, EMPTY=3.
REQ-011 Port overrun, output, 1 bit: sticky flag, set when a step was dropped.

Function
REQ-012 step_clk SHALL be synchronized through two flops and then rising-edge detected, giving a one-cycle step pulse.
REQ-013 The led output SHALL update on the third rising edge of clk_in after step_clk rises, provided input setup is met.
REQ-014 IDLE: led=0; on a step with run=1, go to FILL and apply the FILL update on that same step.
REQ-015 FILL: each step SHALL set led = {led[WIDTH-2:0],1}.
REQ-016 FILL exit: the step that makes led all-ones SHALL move to HOLD (macro defined) or EMPTY (macro undefined).
REQ-017 HOLD: led unchanged; after HOLD_STEPS steps, go to EMPTY, and the HOLD_STEPS-th step SHALL itself perform the first EMPTY update.
REQ-018 EMPTY: each step SHALL set led = {led[WIDTH-2:0],0}; the step that makes led zero SHALL move to FILL.
REQ-019 run=0 in any non-IDLE state SHALL, on the next clk_in edge and independent of step, force IDLE and led=0, and raise led_valid if led was nonzero.
REQ-020 Every change of led SHALL assert led_valid on the same edge; led_valid SHALL stay high with led stable until a cycle in which led_ready=1.
REQ-021 When led_valid=1 and led_ready=1 on the same edge, the transfer completes and led_valid SHALL clear unless a new update occurs on that edge.
REQ-022 A step arriving while led_valid=1 and led_ready=0 SHALL be dropped with no state change, and overrun SHALL be set.
REQ-023 A step coinciding with led_ready=1 SHALL be accepted; the pattern advances and led_valid remains 1.
REQ-024 The hold counter SHALL be ceil(log2(HOLD_STEPS+1)) bits wide and cleared on HOLD entry.

Reset
REQ-025 With rst_n=0 at a clk_in edge: led=0, led_valid=0, phase=IDLE, overrun=0, synchronizer flops=0, hold counter=0.
REQ-026 Step detection SHALL be suppressed for the first 3 cycles after reset release, so a high step_clk at release is not a step.
REQ-027 Reset asserted mid-sequence SHALL abandon any pending transfer without waiting for led_ready.

Configuration
REQ-028 Macro LED_HOLD_EN: when defined, the HOLD state and hold counter exist.
REQ-029 When LED_HOLD_EN is undefined, the HOLD state and hold counter SHALL NOT exist, FILL goes directly to EMPTY, and phase never equals 2.

Structure
REQ-030 Package led_seq_pkg SHALL hold the phase state typedef and its encodings, plus the default WIDTH constant.
REQ-031 Sub-module step_sync SHALL contain the two-flop synchronizer, the edge detector and the post-reset suppression.

Verification
REQ-032 Reset, run=1, led_ready=1, 8 steps: led = 01, 03, 07, ... FF; phase 1, then 2 (LED_HOLD_EN defined).
REQ-033 LED_HOLD_EN defined, HOLD_STEPS=4: 4 steps after FF -> led=FE, phase=3; 7 more steps -> 00, then the next step gives 01 with phase=1.
REQ-034 LED_HOLD_EN undefined: the step after FF gives FE directly; phase never equals 2.
REQ-035 led_ready=0, 2 steps from led=03: led stays 07, overrun=1, led_valid stays 1 until led_ready=1.
REQ-036 run dropped with led=1F: the next cycle gives led=00, phase=0, led_valid=1.
REQ-037 step_clk held high across reset release: no step occurs and led stays 00 until step_clk rises again.
